// File: rtl/nrisc_wb_bridge_pkg.sv
// Shared definitions for the nRISC Wishbone bridge: default widths, timeout and FSM encoding.
// Pure declarations; no logic, no latency.
// Backpressure is not applicable at package level.
package nrisc_wb_bridge_pkg;

    // Default data word width and bus address width of the data-memory BUS port
    localparam int TAM_DEF     = 16;
    localparam int N_DDATA_DEF = 8;

    // Default abort threshold, in cycles spent in ACTIVE
    localparam int WB_TIMEOUT  = 16;

    // 2-bit bridge state encoding
    typedef enum logic [1:0] {
        BR_IDLE   = 2'd0,
        BR_ACTIVE = 2'd1,
        BR_DONE   = 2'd2
    } br_state_t;

    // Width of the timeout counter; never below one bit
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/nrisc_wb_bridge.sv
// Wishbone classic single-beat master driven by start pulses from the nRISC core's data-memory BUS port.
// Start-to-done latency is 2 edges with a zero-wait slave, and TIMEOUT+1 edges when the slave stalls and the cycle is aborted.
// No queueing: a start is accepted only in IDLE, and a slave that stalls is aborted with err after TIMEOUT cycles.
module nrisc_wb_bridge
    import nrisc_wb_bridge_pkg::*;
#(
    parameter int TAM     = TAM_DEF,
    parameter int N_DData = N_DDATA_DEF,
    parameter int TIMEOUT = WB_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               BRIDGE_start,
    input  logic               BRIDGE_we,
    input  logic [N_DData-1:0] BRIDGE_addr,
    input  logic [TAM-1:0]     BRIDGE_wdata,
    output logic [TAM-1:0]     BRIDGE_rdata,
    output logic               BRIDGE_busy,
    output logic               BRIDGE_done,
    output logic               BRIDGE_err,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [N_DData-1:0] wb_adr_o,
    output logic [TAM-1:0]     wb_dat_o,
    input  logic [TAM-1:0]     wb_dat_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i
);

    localparam int                CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

    br_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             cyc;

    // Single-beat cycles: strobe is never deasserted inside a cycle
    assign wb_cyc_o = cyc;
    assign wb_stb_o = cyc;

    // Bridge FSM with all outputs registered; reset drops cyc/stb immediately without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BR_IDLE;
            cnt          <= '0;
            cyc          <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            BRIDGE_rdata <= '0;
            BRIDGE_busy  <= 1'b0;
            BRIDGE_done  <= 1'b0;
            BRIDGE_err   <= 1'b0;
        end else begin
            case (state)
                BR_IDLE: begin
                    if (BRIDGE_start) begin
                        wb_adr_o    <= BRIDGE_addr;
                        wb_dat_o    <= BRIDGE_wdata;
                        wb_we_o     <= BRIDGE_we;
                        BRIDGE_err  <= 1'b0;
                        cnt         <= '0;
                        cyc         <= 1'b1;
                        BRIDGE_busy <= 1'b1;
                        state       <= BR_ACTIVE;
                    end
                end
                BR_ACTIVE: begin
                    // Error takes priority over a simultaneous acknowledge
                    if (wb_err_i) begin
                        BRIDGE_err  <= 1'b1;
                        cyc         <= 1'b0;
                        BRIDGE_done <= 1'b1;
                        state       <= BR_DONE;
                    end else if (wb_ack_i) begin
                        if (!wb_we_o) begin
                            BRIDGE_rdata <= wb_dat_i;
                        end
                        cyc         <= 1'b0;
                        BRIDGE_done <= 1'b1;
                        state       <= BR_DONE;
                    end else if (cnt == CNT_MAX) begin
                        // Stalled slave: abort before the counter could wrap
                        BRIDGE_err  <= 1'b1;
                        cyc         <= 1'b0;
                        BRIDGE_done <= 1'b1;
                        state       <= BR_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BR_DONE: begin
                    BRIDGE_done <= 1'b0;
                    BRIDGE_busy <= 1'b0;
                    state       <= BR_IDLE;
                end
                default: begin
                    state <= BR_IDLE;
                end
            endcase
        end
    end

endmodule
